// File: rtl/mm_pkg.sv
// Shared definitions for the matrix_multiplier host port driver: widths,
// memory read latency and the driver state encoding.
package mm_pkg;

    localparam int MM_DATA_WIDTH  = 32;
    localparam int MM_ADDR_WIDTH  = 12;
    localparam int MEM_RD_LATENCY = 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        WAIT_RES = 2'd2,
        READ     = 2'd3
    } state_t;

endpackage

// File: rtl/mm_stream_buffer.sv
// Two-entry FIFO holding result words between the memory read port and the
// result stream; a pop on empty or a push on full without a pop is ignored.
module mm_stream_buffer
    import mm_pkg::*;
#(
    parameter int DATA_WIDTH = MM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] entry_q [2];
    logic [DATA_WIDTH-1:0] entry_d [2];
    logic                  rd_idx_q, rd_idx_d;
    logic                  wr_idx_q, wr_idx_d;
    logic [1:0]            count_q, count_d;
    logic                  pop_ok, push_ok;

    assign pop_ok    = pop && (count_q != 2'd0);
    assign push_ok   = push && ((count_q != 2'd2) || pop_ok);
    assign count     = count_q;
    assign head_data = entry_q[rd_idx_q];

    always_comb begin
        entry_d  = entry_q;
        rd_idx_d = rd_idx_q;
        wr_idx_d = wr_idx_q;
        count_d  = count_q;
        if (push_ok) begin
            entry_d[wr_idx_q] = push_data;
            wr_idx_d          = ~wr_idx_q;
        end
        if (pop_ok) begin
            rd_idx_d = ~rd_idx_q;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 2'd1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            rd_idx_q   <= 1'b0;
            wr_idx_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            entry_q  <= entry_d;
            rd_idx_q <= rd_idx_d;
            wr_idx_q <= wr_idx_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mm_host_port_driver.sv
// Host-side initiator for the matrix_multiplier memory port: streams operands
// into memory from address 0, then reads the result region back as a stream.
module mm_host_port_driver
    import mm_pkg::*;
#(
    parameter int DATA_WIDTH = MM_DATA_WIDTH,
    parameter int ADDR_WIDTH = MM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] load_len,
    input  logic [ADDR_WIDTH-1:0] res_base,
    input  logic [ADDR_WIDTH-1:0] res_len,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write_enable,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  result_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] load_rem_q, load_rem_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_rem_q, rd_rem_d;
    logic [ADDR_WIDTH-1:0] pop_rem_q, pop_rem_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_data_in_q, mem_data_in_d;
    logic                  mem_we_q, mem_we_d;
    logic                  in_flight_q, in_flight_d;
    logic                  done_q, done_d;
    logic [1:0]            buf_count;
    logic                  pop;
    logic                  issue;
    logic [2:0]            level;

    mm_stream_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (in_flight_q),
        .push_data (mem_data_out),
        .pop       (pop),
        .count     (buf_count),
        .head_data (out_data)
    );

    assign out_valid        = (buf_count != 2'd0);
    assign pop              = out_valid && out_ready;
    assign in_ready         = (state_q == LOAD);
    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign mem_data_in      = mem_data_in_q;
    assign mem_write_enable = mem_we_q;
    // Read addresses are presented combinationally so the word returns in time
    // to be counted by the single in-flight flag.
    assign mem_address      = (state_q == READ) ? rd_ptr_q : mem_address_q;

    assign level = 3'(buf_count) + 3'(in_flight_q) - 3'(pop);
    assign issue = (state_q == READ) && (rd_rem_q != '0) && (level < 3'd2);

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        load_rem_d    = load_rem_q;
        rd_ptr_d      = rd_ptr_q;
        rd_rem_d      = rd_rem_q;
        pop_rem_d     = pop_rem_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        mem_we_d      = 1'b0;
        in_flight_d   = 1'b0;
        done_d        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    wr_ptr_d   = '0;
                    load_rem_d = load_len;
                    rd_ptr_d   = res_base;
                    rd_rem_d   = res_len;
                    pop_rem_d  = res_len;
                    state_d    = (load_len == '0) ? WAIT_RES : LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    mem_we_d      = 1'b1;
                    mem_data_in_d = in_data;
                    mem_address_d = wr_ptr_q;
                    wr_ptr_d      = wr_ptr_q + ADDR_ONE;
                    load_rem_d    = load_rem_q - ADDR_ONE;
                    if (load_rem_q == ADDR_ONE) begin
                        state_d = WAIT_RES;
                    end
                end
            end
            WAIT_RES: begin
                if (pop_rem_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (result_ready) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (issue) begin
                    rd_ptr_d    = rd_ptr_q + ADDR_ONE;
                    rd_rem_d    = rd_rem_q - ADDR_ONE;
                    in_flight_d = 1'b1;
                end
                if (pop) begin
                    pop_rem_d = pop_rem_q - ADDR_ONE;
                    if (pop_rem_q == ADDR_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            load_rem_q    <= '0;
            rd_ptr_q      <= '0;
            rd_rem_q      <= '0;
            pop_rem_q     <= '0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            mem_we_q      <= 1'b0;
            in_flight_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            load_rem_q    <= load_rem_d;
            rd_ptr_q      <= rd_ptr_d;
            rd_rem_q      <= rd_rem_d;
            pop_rem_q     <= pop_rem_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            mem_we_q      <= mem_we_d;
            in_flight_q   <= in_flight_d;
            done_q        <= done_d;
        end
    end

endmodule

// File: tb/tb_mm_host_port_driver.sv
// Bench for mm_host_port_driver: a behavioural memory with 1-cycle read latency
// stands in for matrix_multiplier, and a scoreboard checks the result stream.
module tb_mm_host_port_driver;

    localparam int DW = 32;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] load_len = '0;
    logic [AW-1:0] res_base = '0;
    logic [AW-1:0] res_len = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] mem_data_in;
    logic [AW-1:0] mem_address;
    logic          mem_write_enable;
    logic [DW-1:0] mem_data_out = '0;
    logic          result_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;

    int compared = 0;
    int mismatched = 0;
    int cycle_cnt = 0;
    int done_cnt = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          tb_we = 1'b0;
    logic [AW-1:0] tb_addr = '0;
    logic [DW-1:0] tb_wdata = '0;

    logic [DW-1:0] exp_q [$];
    int            wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    int            wr_cyc_q [$];
    logic          wr_inrdy_q [$];
    int            pop_cyc_q [$];
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;
    logic [DW-1:0] load_buf [8];

    int a_mat [4] = '{1, 2, 3, 4};
    int b_mat [4] = '{5, 6, 7, 8};

    mm_host_port_driver #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .load_len         (load_len),
        .res_base         (res_base),
        .res_len          (res_len),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .mem_data_in      (mem_data_in),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_data_out     (mem_data_out),
        .result_ready     (result_ready),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle_cnt <= cycle_cnt + 1;
        if (tb_we) begin
            mem[tb_addr] <= tb_wdata;
        end else if (mem_write_enable) begin
            mem[mem_address] <= mem_data_in;
        end
        mem_data_out <= mem[mem_address];
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Monitor: log writes, score popped words, check stall stability and done.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (mem_write_enable) begin
                wr_addr_q.push_back(int'(mem_address));
                wr_data_q.push_back(mem_data_in);
                wr_cyc_q.push_back(cycle_cnt);
                wr_inrdy_q.push_back(in_ready);
            end
            if (stall_prev && out_valid) begin
                checkOutput("stall_hold", out_data, stall_data);
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            if (out_valid && out_ready) begin
                pop_cyc_q.push_back(cycle_cnt);
                if (exp_q.size() == 0) begin
                    checkOutput("out_extra", DW'(exp_q.size()), 32'd1);
                end else begin
                    checkOutput("out_data", out_data, exp_q.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                checkOutput("busy_at_done", DW'(busy), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int ll, input int rb, input int rl);
        start    = 1'b1;
        load_len = AW'(ll);
        res_base = AW'(rb);
        res_len  = AW'(rl);
        tick();
        start = 1'b0;
    endtask

    task automatic tb_write(input int addr, input logic [DW-1:0] data);
        tb_we    = 1'b1;
        tb_addr  = AW'(addr);
        tb_wdata = data;
        tick();
        tb_we = 1'b0;
    endtask

    task automatic load_words(input int n);
        for (int k = 0; k < n; k++) begin
            int guard = 0;
            in_data  = load_buf[k];
            in_valid = 1'b1;
            while (!in_ready && guard < 20) begin
                tick();
                guard++;
            end
            checkOutput("in_ready_seen", DW'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input logic [3:0] pat);
        int start_done = done_cnt;
        int i = 0;
        while (done_cnt == start_done && i < budget) begin
            out_ready = pat[i % 4];
            tick();
            i++;
        end
        out_ready = 1'b1;
        repeat (4) tick();
        checkOutput("done_once", DW'(done_cnt - start_done), 32'd1);
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        wr_inrdy_q.delete();
        pop_cyc_q.delete();
    endtask

    function automatic logic [DW-1:0] golden(input int i, input int j);
        return DW'(a_mat[i*2] * b_mat[j] + a_mat[i*2+1] * b_mat[2+j]);
    endfunction

    task automatic run_matmul(input logic [3:0] pat);
        clear_logs();
        for (int k = 0; k < 4; k++) begin
            load_buf[k]   = DW'(a_mat[k]);
            load_buf[k+4] = DW'(b_mat[k]);
        end
        applyStimulus(8, 8, 4);
        load_words(8);
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                logic [DW-1:0] c;
                c = mem[i*2] * mem[4+j] + mem[i*2+1] * mem[6+j];
                tb_write(8 + i*2 + j, c);
                exp_q.push_back(golden(i, j));
            end
        end
        result_ready = 1'b1;
        wait_done(200, pat);
        result_ready = 1'b0;
        checkOutput("mm_writes", DW'(wr_addr_q.size()), 32'd8);
        checkOutput("mm_pops", DW'(pop_cyc_q.size()), 32'd4);
        checkOutput("exp_drained", DW'(exp_q.size()), 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        checkOutput("rst_in_ready", DW'(in_ready), 32'd0);
        checkOutput("rst_we", DW'(mem_write_enable), 32'd0);
        checkOutput("rst_out_valid", DW'(out_valid), 32'd0);
        checkOutput("rst_busy", DW'(busy), 32'd0);
        checkOutput("rst_done", DW'(done), 32'd0);
        checkOutput("rst_addr", DW'(mem_address), 32'd0);
        checkOutput("rst_wdata", mem_data_in, 32'd0);
        reset = 1'b0;
        tick();

        $display("[TB] test 1: three-word load");
        clear_logs();
        load_buf[0] = 32'hA;
        load_buf[1] = 32'hB;
        load_buf[2] = 32'hC;
        applyStimulus(3, 0, 0);
        load_words(3);
        wait_done(20, 4'hF);
        checkOutput("t1_nwrites", DW'(wr_addr_q.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            checkOutput("t1_addr", DW'(wr_addr_q[k]), DW'(k));
            checkOutput("t1_data", wr_data_q[k], DW'(32'hA + k));
        end
        checkOutput("t1_consec", DW'(wr_cyc_q[2] - wr_cyc_q[0]), 32'd2);
        checkOutput("t1_in_ready_drop", DW'(wr_inrdy_q[2]), 32'd0);

        $display("[TB] test 2: 2x2 multiply, out_ready held");
        run_matmul(4'hF);
        checkOutput("t2_consec", DW'(pop_cyc_q[3] - pop_cyc_q[0]), 32'd3);

        $display("[TB] test 3: 2x2 multiply, out_ready toggling");
        run_matmul(4'b1001);

        $display("[TB] test 4: empty load and result");
        clear_logs();
        result_ready = 1'b1;
        applyStimulus(0, 0, 0);
        wait_done(10, 4'hF);
        result_ready = 1'b0;
        checkOutput("t4_writes", DW'(wr_addr_q.size()), 32'd0);
        checkOutput("t4_pops", DW'(pop_cyc_q.size()), 32'd0);

        $display("[TB] test 5: read address wrap");
        clear_logs();
        tb_write(4094, 32'h1111_0FFE);
        tb_write(4095, 32'h2222_0FFF);
        tb_write(0, 32'h3333_0000);
        tb_write(1, 32'h4444_0001);
        exp_q.push_back(32'h1111_0FFE);
        exp_q.push_back(32'h2222_0FFF);
        exp_q.push_back(32'h3333_0000);
        exp_q.push_back(32'h4444_0001);
        result_ready = 1'b1;
        applyStimulus(0, 4094, 4);
        wait_done(100, 4'hF);
        result_ready = 1'b0;
        checkOutput("t5_pops", DW'(pop_cyc_q.size()), 32'd4);
        checkOutput("t5_drained", DW'(exp_q.size()), 32'd0);

        $display("[TB] test 6: reset during READ");
        begin
            int guard = 0;
            out_ready    = 1'b0;
            result_ready = 1'b1;
            applyStimulus(0, 20, 4);
            while (!out_valid && guard < 20) begin
                tick();
                guard++;
            end
            checkOutput("t6_buffered", DW'(out_valid), 32'd1);
            reset = 1'b1;
            tick();
            checkOutput("t6_out_valid", DW'(out_valid), 32'd0);
            checkOutput("t6_we", DW'(mem_write_enable), 32'd0);
            checkOutput("t6_busy", DW'(busy), 32'd0);
            reset        = 1'b0;
            result_ready = 1'b0;
            out_ready    = 1'b1;
            exp_q.delete();
            tick();
        end
        run_matmul(4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cycle_cnt);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
